// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: key-length encoding, Nk/Nr lookup,
// the Rcon table, GF(2^8) doubling and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128 = 2'b00,
    KEY_192 = 2'b01,
    KEY_256 = 2'b10,
    KEY_BAD = 2'b11
  } key_len_e;

  // Key length in 32-bit words.
  function automatic logic [3:0] nk_of(input key_len_e len);
    case (len)
      KEY_128: nk_of = 4'd4;
      KEY_192: nk_of = 4'd6;
      default: nk_of = 4'd8;
    endcase
  endfunction

  // Number of cipher rounds; the schedule holds Nr+1 round keys.
  function automatic logic [3:0] nr_of(input key_len_e len);
    case (len)
      KEY_128: nr_of = 4'd10;
      KEY_192: nr_of = 4'd12;
      default: nr_of = 4'd14;
    endcase
  endfunction

  // Round constants in schedule order; the engine regenerates them with
  // xtime, this table is the reference sequence for the cipher side.
  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward S-box, element 0 leftmost.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four independent S-box lookups across a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Byte-wise substitution, purely combinational.
  always_comb begin
    word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};
  end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: one schedule word per cycle into
// a word buffer, with round keys readable as soon as their fourth word lands.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int SBOX_REG = 0,
  parameter int MAX_NK   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int WORDS = 4 * (MAX_NK + 7);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_EXPAND = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]   state_q, state_d;
  key_len_e     len_q, len_d;
  logic [255:0] key_q, key_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   j_q, j_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         err_q, err_d;
  logic         sub_wait_q, sub_wait_d;
  logic [31:0]  w_q [WORDS];
  logic [31:0]  w_d [WORDS];

  logic [3:0]  nk, nr;
  logic [5:0]  last_idx, rd_base;
  logic [31:0] prev_word, back_word, sub_in, sub_out, sub_res, temp;
  logic        rot_step, sub_step;

  assign nk        = nk_of(len_q);
  assign nr        = nr_of(len_q);
  assign last_idx  = {nr, 2'b11};
  assign prev_word = w_q[i_q - 6'd1];
  assign back_word = w_q[i_q - {2'b00, nk}];
  assign rot_step  = (j_q == 3'd0);
  assign sub_step  = rot_step || (nk == 4'd8 && j_q == 3'd4);
  assign sub_in    = rot_step ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_sub_word u_sub_word (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // Optional pipeline stage after the S-box; the engine waits one extra
  // cycle on S-box words so the captured value is the one for word i.
  if (SBOX_REG != 0) begin : g_sub_reg
    logic [31:0] sub_q, sub_d;
    assign sub_d   = sub_out;
    assign sub_res = sub_q;
    // Capture SubWord output every cycle; it is consumed on the second cycle.
    always_ff @(posedge clk) begin
      sub_q <= sub_d;
    end
  end else begin : g_sub_comb
    assign sub_res = sub_out;
  end

  // Schedule word recurrence: RotWord/SubWord/Rcon every Nk words, plus the
  // extra SubWord half-way through each 8-word group for AES-256.
  always_comb begin
    temp = prev_word;
    if (rot_step) begin
      temp = sub_res ^ {rcon_q, 24'h000000};
    end else if (sub_step) begin
      temp = sub_res;
    end
  end

  // Next-state logic: FSM, counters, rcon and buffer writes; a start pulse
  // overrides whatever the engine was doing so a new key always restarts.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    key_d      = key_q;
    i_d        = i_q;
    j_d        = j_q;
    rcon_d     = rcon_q;
    err_d      = err_q;
    sub_wait_d = sub_wait_q;
    w_d        = w_q;
    case (state_q)
      ST_LOAD: begin
        for (int k = 0; k < MAX_NK; k++) begin
          if (k < int'(nk)) w_d[k] = key_q[255 - 32*k -: 32];
        end
        i_d        = {2'b00, nk};
        j_d        = 3'd0;
        rcon_d     = 8'h01;
        sub_wait_d = 1'b0;
        state_d    = ST_EXPAND;
      end
      ST_EXPAND: begin
        if (SBOX_REG != 0 && sub_step && !sub_wait_q) begin
          sub_wait_d = 1'b1;
        end else begin
          sub_wait_d = 1'b0;
          w_d[i_q]   = back_word ^ temp;
          if (rot_step) rcon_d = xtime(rcon_q);
          j_d = ({1'b0, j_q} == nk - 4'd1) ? 3'd0 : j_q + 3'd1;
          i_d = i_q + 6'd1;
          if (i_q == last_idx) state_d = ST_DONE;
        end
      end
      default: ;
    endcase
    if (start) begin
      i_d        = 6'd0;
      sub_wait_d = 1'b0;
      if (key_len == KEY_BAD) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        state_d = ST_LOAD;
        err_d   = 1'b0;
        len_d   = key_len_e'(key_len);
        key_d   = key_in;
      end
    end
  end

  // Control registers with synchronous reset; the word counter at zero is
  // what invalidates every round key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= KEY_128;
      key_q      <= '0;
      i_q        <= 6'd0;
      j_q        <= 3'd0;
      rcon_q     <= 8'h01;
      err_q      <= 1'b0;
      sub_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      key_q      <= key_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rcon_q     <= rcon_d;
      err_q      <= err_d;
      sub_wait_q <= sub_wait_d;
    end
  end

  // Word buffer: contents are only trusted below the word counter, so no reset.
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  // Round-key read port: a key is valid once all four words are below i.
  always_comb begin
    rd_base  = {rk_idx, 2'b00};
    rk_valid = (rk_idx <= nr) && (({1'b0, rd_base} + 7'd4) <= {1'b0, i_q});
    rk_out   = '0;
    if (rk_valid) begin
      rk_out = {w_q[rd_base], w_q[rd_base + 6'd1],
                w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end
  end

  assign busy = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for the key expander: both S-box timing variants run side
// by side on the same stimulus against FIPS-197 reference round keys.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   keyLen;
  logic [255:0] keyIn;
  logic [3:0]   rkIdx;
  logic [127:0] rkOut0, rkOut1;
  logic         rkValid0, rkValid1;
  logic         busy0, busy1, done0, done1, err0, err1;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  always #5 clk = ~clk;

  aes_key_expander #(.SBOX_REG(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key_len(keyLen), .key_in(keyIn),
    .rk_idx(rkIdx), .rk_out(rkOut0), .rk_valid(rkValid0),
    .busy(busy0), .done(done0), .err(err0)
  );

  aes_key_expander #(.SBOX_REG(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .key_len(keyLen), .key_in(keyIn),
    .rk_idx(rkIdx), .rk_out(rkOut1), .rk_valid(rkValid1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle start pulse; returns just after the edge that sampled it.
  task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key);
    keyLen = len;
    keyIn  = key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic readRound(input logic [3:0] idx);
    rkIdx = idx;
    #1;
  endtask

  // Counts edges after the start edge until each instance reports done;
  // optionally records when round key 1 first becomes readable on dut0.
  task automatic waitDone(input bit poll, output int lat0, output int lat1,
                          output int streamAt);
    lat0 = 0;
    lat1 = 0;
    streamAt = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (poll && streamAt == 0 && rkValid0) streamAt = n;
      if (lat0 == 0 && done0) lat0 = n;
      if (lat1 == 0 && done1) lat1 = n;
      if (lat0 != 0 && lat1 != 0) break;
    end
  endtask

  initial begin
    int lat0, lat1, streamAt;
    rst = 1'b1; start = 1'b0; keyLen = 2'b00; keyIn = '0; rkIdx = 4'd0;
    tick();
    tick();
    checkOutput("rst busy", busy0, 0);
    checkOutput("rst done", done0, 0);
    checkOutput("rst err", err0, 0);
    checkOutput("rst rk_valid", rkValid0, 0);
    checkOutput("rst rk_out", rkOut0, 0);
    checkOutput("rst busy reg", busy1, 0);
    rst = 1'b0;
    tick();

    $display("[TB] AES-128 with streaming poll of round 1");
    rkIdx = 4'd1;
    applyStimulus(2'b00, KEY128);
    waitDone(1'b1, lat0, lat1, streamAt);
    checkOutput("t1 stream rk1", streamAt, 5);
    checkOutput("t1 latency", lat0, 41);
    checkOutput("t1 latency reg", lat1, 51);
    checkOutput("t1 done", done0, 1);
    checkOutput("t1 busy", busy0, 0);
    readRound(4'd0);
    checkOutput("t1 rk0", rkOut0, RK128_0);
    readRound(4'd1);
    checkOutput("t1 rk1", rkOut0, RK128_1);
    readRound(4'd10);
    checkOutput("t1 rk10", rkOut0, RK128_10);
    checkOutput("t1 rk10 reg", rkOut1, RK128_10);
    readRound(4'd11);
    checkOutput("t1 rk11 valid", rkValid0, 0);
    checkOutput("t1 rk11 out", rkOut0, 0);

    $display("[TB] AES-192, key inputs disturbed after start");
    applyStimulus(2'b01, KEY192);
    keyIn  = '1;
    keyLen = 2'b00;
    waitDone(1'b0, lat0, lat1, streamAt);
    checkOutput("t2 latency", lat0, 47);
    checkOutput("t2 latency reg", lat1, 55);
    readRound(4'd1);
    checkOutput("t2 rk1", rkOut0, RK192_1);
    readRound(4'd12);
    checkOutput("t2 rk12", rkOut0, RK192_12);
    checkOutput("t2 rk12 reg", rkOut1, RK192_12);
    readRound(4'd13);
    checkOutput("t2 rk13 valid", rkValid0, 0);

    $display("[TB] AES-256");
    applyStimulus(2'b10, KEY256);
    waitDone(1'b0, lat0, lat1, streamAt);
    checkOutput("t3 latency", lat0, 53);
    checkOutput("t3 latency reg", lat1, 66);
    readRound(4'd2);
    checkOutput("t3 rk2", rkOut0, RK256_2);
    readRound(4'd14);
    checkOutput("t3 rk14", rkOut0, RK256_14);
    checkOutput("t3 rk14 reg", rkOut1, RK256_14);

    $display("[TB] illegal key length");
    applyStimulus(2'b11, KEY128);
    checkOutput("t6 err", err0, 1);
    checkOutput("t6 busy", busy0, 0);
    checkOutput("t6 done", done0, 0);
    checkOutput("t6 err reg", err1, 1);

    $display("[TB] restart AES-256 with AES-128 key mid-run");
    applyStimulus(2'b10, KEY256);
    checkOutput("t5 err cleared", err0, 0);
    for (int c = 0; c < 19; c++) tick();
    applyStimulus(2'b00, KEY128);
    rkIdx = 4'd0;
    #1;
    checkOutput("t5 rk0 dropped", rkValid0, 0);
    checkOutput("t5 done dropped", done0, 0);
    checkOutput("t5 busy", busy0, 1);
    waitDone(1'b0, lat0, lat1, streamAt);
    checkOutput("t5 latency", lat0, 41);
    checkOutput("t5 latency reg", lat1, 51);
    readRound(4'd1);
    checkOutput("t5 rk1", rkOut0, RK128_1);
    readRound(4'd10);
    checkOutput("t5 rk10", rkOut0, RK128_10);
    checkOutput("t5 rk10 reg", rkOut1, RK128_10);
    readRound(4'd14);
    checkOutput("t5 rk14 valid", rkValid0, 0);

    $display("[TB] reset mid-expansion");
    applyStimulus(2'b00, KEY128);
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    readRound(4'd0);
    checkOutput("t5 rst busy", busy0, 0);
    checkOutput("t5 rst done", done0, 0);
    checkOutput("t5 rst rk0 valid", rkValid0, 0);
    checkOutput("t5 rst busy reg", busy1, 0);

    $display("[TB] start coincident with reset");
    rst = 1'b1;
    applyStimulus(2'b00, KEY128);
    rst = 1'b0;
    checkOutput("rst+start busy", busy0, 0);
    tick();
    checkOutput("rst+start busy later", busy0, 0);
    checkOutput("rst+start done", done0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
